varredor_teclado: RTL and testbench

//  Scans an N_COLS x N_ROWS push-button matrix that shares the column/row wiring of the LED matrix.
//  - Drives one column low at a time and samples the rows.
//  - Debounces every key and reports each debounced press as a coded event, using a valid/ack handshake.
//  - The control unit consumes these events in place of the per-button edge detector.

---
 rtl/varredor_teclado.sv | 163 ++++++++++++++++
 tb/tb_varredor_teclado.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/varredor_teclado.sv
// Key-matrix scanner: drives one column low at a time, debounces every key and reports presses
// as {col,row} events over a valid/ack handshake. Define ANTI_GHOST_EN to discard multi-row column samples.
module varredor_teclado #(
  parameter int N_COLS         = 8,
  parameter int N_ROWS         = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       enable,
  input  logic [N_ROWS-1:0]                          linhas_in,
  output logic [N_COLS-1:0]                          colunas_out,
  output logic                                       tecla_valida,
  output logic [$clog2(N_COLS)+$clog2(N_ROWS)-1:0]   tecla_codigo,
  input  logic                                       tecla_ack,
  output logic [N_COLS*N_ROWS-1:0]                   pressionadas,
  output logic [1:0]                                 db_estado
);

  localparam int CW    = $clog2(N_COLS);
  localparam int RW    = $clog2(N_ROWS);
  localparam int NK    = N_COLS * N_ROWS;
  localparam int KW    = $clog2(NK);
  localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DRIVE  = 2'b01,
    SAMPLE = 2'b10,
    NEXT   = 2'b11
  } state_t;

  // Handshake: an event is pending while tecla_valida=1; it is consumed on the
  // rising edge where tecla_ack=1 and tecla_valida=1. tecla_ack alone is ignored.

  state_t              state_q, state_d;
  logic [CW-1:0]       col_q, col_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [N_COLS-1:0]   colunas_q, colunas_d;
  logic                valida_q, valida_d;
  logic [CW+RW-1:0]    codigo_q, codigo_d;
  logic [NK-1:0]       press_q, press_d;
  logic [CNT_W-1:0]    cnt_q [NK];
  logic [CNT_W-1:0]    cnt_d [NK];

  logic [N_ROWS-1:0]   raw;
  logic                ghost;
  logic                slot_free;
  logic                granted;
  logic [KW-1:0]       base;
  logic [KW-1:0]       kidx;
`ifdef ANTI_GHOST_EN
  int                  ones;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    settle_d  = settle_q;
    colunas_d = colunas_q;
    valida_d  = valida_q;
    codigo_d  = codigo_q;
    press_d   = press_q;
    cnt_d     = cnt_q;
    raw       = ~linhas_in;
    ghost     = 1'b0;
    slot_free = !valida_q || tecla_ack;
    granted   = 1'b0;
    base      = KW'(col_q) * KW'(N_ROWS);
    kidx      = '0;

`ifdef ANTI_GHOST_EN
    ones = 0;
    for (int r = 0; r < N_ROWS; r++) ones = ones + int'(raw[r]);
    ghost = (ones >= 2);
`endif

    if (valida_q && tecla_ack) valida_d = 1'b0;

    if (!enable) begin
      state_d   = IDLE;
      col_d     = '0;
      settle_d  = '0;
      colunas_d = '1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d          = DRIVE;
          settle_d         = '0;
          colunas_d        = '1;
          colunas_d[col_q] = 1'b0;
        end
        DRIVE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
          else settle_d = settle_q + 1'b1;
        end
        SAMPLE: begin
          state_d   = NEXT;
          colunas_d = '1;
          if (!ghost) begin
            for (int r = 0; r < N_ROWS; r++) begin
              kidx = base + KW'(r);
              if (raw[r] == press_q[kidx]) begin
                cnt_d[kidx] = '0;
              end else if (cnt_q[kidx] != CNT_W'(DEBOUNCE_SCANS - 1)) begin
                cnt_d[kidx] = cnt_q[kidx] + 1'b1;
              end else if (!raw[r]) begin
                press_d[kidx] = 1'b0;
                cnt_d[kidx]   = '0;
              end else if (slot_free && !granted) begin
                // Lowest row wins the slot; other ready presses keep their saturated count and retry.
                press_d[kidx] = 1'b1;
                cnt_d[kidx]   = '0;
                granted       = 1'b1;
                valida_d      = 1'b1;
                codigo_d      = {col_q, RW'(r)};
              end
            end
          end
        end
        NEXT: begin
          col_d            = (col_q == CW'(N_COLS - 1)) ? '0 : col_q + 1'b1;
          state_d          = DRIVE;
          settle_d         = '0;
          colunas_d        = '1;
          colunas_d[col_d] = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      col_q     <= '0;
      settle_q  <= '0;
      colunas_q <= '1;
      valida_q  <= 1'b0;
      codigo_q  <= '0;
      press_q   <= '0;
      for (int k = 0; k < NK; k++) cnt_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      settle_q  <= settle_d;
      colunas_q <= colunas_d;
      valida_q  <= valida_d;
      codigo_q  <= codigo_d;
      press_q   <= press_d;
      for (int k = 0; k < NK; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign colunas_out  = colunas_q;
  assign tecla_valida = valida_q;
  assign tecla_codigo = codigo_q;
  assign pressionadas = press_q;
  assign db_estado    = state_q;

endmodule

// File: tb/tb_varredor_teclado.sv
// Directed bench for varredor_teclado: a key-matrix model answers the column drive,
// expected values are hand-derived for the 8x8 / settle 16 / debounce 4 defaults.
module tb_varredor_teclado;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [7:0]  linhas_in;
  logic [7:0]  colunas_out;
  logic        tecla_valida;
  logic [5:0]  tecla_codigo;
  logic        tecla_ack;
  logic [63:0] pressionadas;
  logic [1:0]  db_estado;

  logic [63:0] key_map;
  int          errors;
  int          checks;

  varredor_teclado dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .linhas_in    (linhas_in),
    .colunas_out  (colunas_out),
    .tecla_valida (tecla_valida),
    .tecla_codigo (tecla_codigo),
    .tecla_ack    (tecla_ack),
    .pressionadas (pressionadas),
    .db_estado    (db_estado)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    linhas_in = 8'hFF;
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++)
        if (!colunas_out[c] && key_map[c*8+r]) linhas_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns at the negedge inside the SAMPLE cycle of column c.
  task automatic wait_sample(input int c);
    logic [7:0] m;
    bit found;
    m = 8'hFF;
    m[c] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (db_estado == 2'b10 && colunas_out == m) found = 1'b1;
    end
    if (!found) check("wait_sample_timeout", 64'd0, 64'd1);
  endtask

  // Returns at the negedge just after the edge that ends SAMPLE of column c.
  task automatic after_sample(input int c);
    wait_sample(c);
    @(negedge clock);
  endtask

  task automatic ack_pulse();
    tecla_ack = 1'b1;
    @(negedge clock);
    tecla_ack = 1'b0;
  endtask

  initial begin
    int  n;
    bit  found;
    errors    = 0;
    checks    = 0;
    reset_n   = 1'b0;
    enable    = 1'b0;
    tecla_ack = 1'b0;
    key_map   = '0;

    repeat (3) @(negedge clock);
    check("rst_colunas", colunas_out, 64'hFF);
    check("rst_valida", tecla_valida, 64'd0);
    check("rst_codigo", tecla_codigo, 64'd0);
    check("rst_press", pressionadas, 64'd0);
    check("rst_estado", db_estado, 64'd0);

    reset_n = 1'b1;
    @(negedge clock);
    check("idle_hold", db_estado, 64'd0);
    enable = 1'b1;
    @(negedge clock);
    check("first_drive_estado", db_estado, 64'd1);
    check("first_drive_col0", colunas_out, 64'hFE);

    // Column period and break-before-make NEXT cycle
    wait_sample(0);
    @(negedge clock);
    check("next_estado", db_estado, 64'd3);
    check("next_colunas", colunas_out, 64'hFF);
    n = 1;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      n++;
      if (db_estado == 2'b10 && colunas_out == 8'hFD) found = 1'b1;
    end
    check("col_period", n, 64'd18);

    // T2: single press of key(2,5)
    key_map[2*8+5] = 1'b1;
    for (int s = 0; s < 3; s++) after_sample(2);
    check("t2_valida_3scans", tecla_valida, 64'd0);
    check("t2_press_3scans", pressionadas, 64'd0);
    after_sample(2);
    check("t2_valida_4scans", tecla_valida, 64'd1);
    check("t2_codigo", tecla_codigo, 64'b010_101);
    check("t2_press_map", pressionadas, 64'd1 << 21);
    after_sample(2);
    check("t2_valida_hold", tecla_valida, 64'd1);
    check("t2_codigo_hold", tecla_codigo, 64'b010_101);
    ack_pulse();
    check("t2_valida_cleared", tecla_valida, 64'd0);
    tecla_ack = 1'b1;
    repeat (5) @(negedge clock);
    tecla_ack = 1'b0;
    check("t2_idle_ack_ignored", tecla_valida, 64'd0);
    key_map[2*8+5] = 1'b0;
    for (int s = 0; s < 3; s++) after_sample(2);
    check("t2_release_3scans", pressionadas, 64'd1 << 21);
    after_sample(2);
    check("t2_release_4scans", pressionadas, 64'd0);
    check("t2_release_silent", tecla_valida, 64'd0);

    // T3: bounce on key(0,0); interrupted runs never commit
    key_map[0] = 1'b1;
    for (int s = 0; s < 3; s++) after_sample(0);
    key_map[0] = 1'b0;
    after_sample(0);
    check("t3_press_bit", pressionadas[0], 64'd0);
    key_map[0] = 1'b1;
    for (int s = 0; s < 3; s++) after_sample(0);
    check("t3_counter_restarted", pressionadas[0], 64'd0);
    check("t3_no_event", tecla_valida, 64'd0);
    key_map[0] = 1'b0;
    after_sample(0);

    // T4: two keys in column 4, lowest row first, second deferred
    key_map[4*8+1] = 1'b1;
    key_map[4*8+6] = 1'b1;
    for (int s = 0; s < 4; s++) after_sample(4);
    check("t4_valida_first", tecla_valida, 64'd1);
    check("t4_codigo_first", tecla_codigo, 64'b100_001);
    check("t4_press_first", pressionadas, 64'd1 << 33);
    after_sample(4);
    check("t4_codigo_held", tecla_codigo, 64'b100_001);
    check("t4_second_deferred", pressionadas, 64'd1 << 33);
    wait_sample(4);
    ack_pulse();
    check("t4_valida_reload", tecla_valida, 64'd1);
    check("t4_codigo_second", tecla_codigo, 64'b100_110);
    check("t4_press_both", pressionadas, (64'd1 << 33) | (64'd1 << 38));
    ack_pulse();
    check("t4_valida_cleared", tecla_valida, 64'd0);
    key_map[4*8+1] = 1'b0;
    key_map[4*8+6] = 1'b0;
    for (int s = 0; s < 4; s++) after_sample(4);
    check("t4_release_map", pressionadas, 64'd0);
    check("t4_release_silent", tecla_valida, 64'd0);

    // T5: drop enable while column 3 is driven
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (db_estado == 2'b01 && colunas_out == 8'hF7) found = 1'b1;
    end
    check("t5_found_col3", found, 64'd1);
    enable = 1'b0;
    @(negedge clock);
    check("t5_idle_estado", db_estado, 64'd0);
    check("t5_idle_colunas", colunas_out, 64'hFF);
    repeat (4) @(negedge clock);
    check("t5_idle_stays", db_estado, 64'd0);
    enable = 1'b1;
    @(negedge clock);
    check("t5_restart_estado", db_estado, 64'd1);
    check("t5_restart_col0", colunas_out, 64'hFE);

    // T6: rows 1 and 2 together in column 5
    key_map[5*8+1] = 1'b1;
    key_map[5*8+2] = 1'b1;
`ifdef ANTI_GHOST_EN
    for (int s = 0; s < 6; s++) after_sample(5);
    check("t6_ag_no_event", tecla_valida, 64'd0);
    check("t6_ag_no_map", pressionadas, 64'd0);
`else
    for (int s = 0; s < 4; s++) after_sample(5);
    check("t6_valida_first", tecla_valida, 64'd1);
    check("t6_codigo_first", tecla_codigo, 64'b101_001);
    check("t6_press_first", pressionadas, 64'd1 << 41);
    ack_pulse();
    check("t6_valida_cleared", tecla_valida, 64'd0);
    after_sample(5);
    check("t6_valida_second", tecla_valida, 64'd1);
    check("t6_codigo_second", tecla_codigo, 64'b101_010);
    check("t6_press_both", pressionadas, (64'd1 << 41) | (64'd1 << 42));
`endif

    // T1: asynchronous reset in the middle of DRIVE
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clock);
      if (db_estado == 2'b01) found = 1'b1;
    end
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("t1_colunas", colunas_out, 64'hFF);
    check("t1_valida", tecla_valida, 64'd0);
    check("t1_press", pressionadas, 64'd0);
    check("t1_estado", db_estado, 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
